// File: rtl/vram_dma.sv
// Bus-master copy engine: uploads a byte block from a synchronous source RAM into
// GPU VRAM, writing only inside vblank and resuming across frames until done.
module vram_dma #(
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter int SRC_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SRC_ADDR_WIDTH-1:0]  src_base,
  input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]       length,
  output logic                       busy,
  output logic                       done,
  output logic                       src_rd,
  output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
  input  logic [7:0]                 src_data,
  output logic [7:0]                 vram_data,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic                       vram_write_enable,
  output logic                       vram_select,
  output logic                       in_vblank_select,
  output logic                       clr_irq_select,
  input  logic [7:0]                 status_in,
  input  logic                       vblank_irq,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_IRQ = 3'd1,
    S_ACK      = 3'd2,
    S_CHECK    = 3'd3,
    S_XFER     = 3'd4,
    S_FINISH   = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [SRC_ADDR_WIDTH-1:0]    src_base_q, src_base_d;
  logic [VRAM_ADDR_WIDTH-1:0]   dst_base_q, dst_base_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic [LEN_WIDTH-1:0]         rd_idx_q, rd_idx_d;
  logic [LEN_WIDTH-1:0]         wr_idx_q, wr_idx_d;
  logic                         pend_q, pend_d;

  logic rd_more;
  logic wr_last;
  logic unused_status;

  // Only the writable flag of the GPU status byte is meaningful here.
  assign unused_status = ^status_in[7:1];

  assign rd_more   = (rd_idx_q < len_q);
  assign wr_last   = ((wr_idx_q + LEN_WIDTH'(1)) == len_q);
  assign busy      = (state_q == S_WAIT_IRQ) || (state_q == S_ACK) ||
                     (state_q == S_CHECK) || (state_q == S_XFER);
  assign done      = (state_q == S_FINISH);
  assign dbg_state = state_q;

  always_comb begin
    state_d           = state_q;
    src_base_d        = src_base_q;
    dst_base_d        = dst_base_q;
    len_d             = len_q;
    rd_idx_d          = rd_idx_q;
    wr_idx_d          = wr_idx_q;
    pend_d            = 1'b0;
    src_rd            = 1'b0;
    src_addr          = '0;
    vram_data         = 8'h00;
    vram_address      = '0;
    vram_write_enable = 1'b0;
    vram_select       = 1'b0;
    in_vblank_select  = 1'b0;
    clr_irq_select    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_base_d = src_base;
            dst_base_d = dst_base;
            len_d      = length;
            rd_idx_d   = '0;
            wr_idx_d   = '0;
            state_d    = S_WAIT_IRQ;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_WAIT_IRQ: begin
        if (vblank_irq) state_d = S_ACK;
      end

      S_ACK: begin
        vram_write_enable = 1'b1;
        clr_irq_select    = 1'b1;
        state_d           = S_CHECK;
      end

      S_CHECK: begin
        in_vblank_select = 1'b1;
        state_d          = status_in[0] ? S_XFER : S_WAIT_IRQ;
      end

      S_XFER: begin
        if (vblank_irq) begin
          // Vblank is over: drop the byte in flight and re-read it next frame.
          rd_idx_d = wr_idx_q;
          state_d  = S_ACK;
        end else begin
          if (rd_more) begin
            src_rd   = 1'b1;
            src_addr = src_base_q + SRC_ADDR_WIDTH'(rd_idx_q);
            rd_idx_d = rd_idx_q + LEN_WIDTH'(1);
            pend_d   = 1'b1;
          end
          if (pend_q) begin
            vram_write_enable = 1'b1;
            vram_select       = 1'b1;
            vram_address      = dst_base_q + VRAM_ADDR_WIDTH'(wr_idx_q);
            vram_data         = src_data;
            wr_idx_d          = wr_idx_q + LEN_WIDTH'(1);
            if (wr_last) begin
              pend_d  = 1'b0;
              state_d = S_FINISH;
            end
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      len_q      <= len_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: tb/tb_vram_dma.sv
// Bench for vram_dma: behavioural GPU irq/status model, synchronous source RAM,
// expected VRAM writes queued at stimulus time and popped by a negedge monitor.
module tb_vram_dma;
  localparam int VA = 12;
  localparam int SA = 16;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [SA-1:0] src_base = '0;
  logic [VA-1:0] dst_base = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, src_rd;
  logic [SA-1:0] src_addr;
  logic [7:0]    src_data = 8'h00;
  logic [7:0]    vram_data;
  logic [VA-1:0] vram_address;
  logic          vram_write_enable, vram_select, in_vblank_select, clr_irq_select;
  logic [7:0]    status_in;
  logic          vblank_irq;
  logic [2:0]    dbg_state;

  // GPU model: irq set on writable/reset edges, cleared by the ACK store.
  logic irq_q = 1'b0;
  logic irq_pulse = 1'b0;
  logic vb = 1'b0;
  logic gpu_rst = 1'b1;
  logic [7:0] src_mem [0:65535];

  logic [19:0] exp_q[$];
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;
  int chk_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = -10;
  int run_len = 0;

  vram_dma #(.VRAM_ADDR_WIDTH(VA), .SRC_ADDR_WIDTH(SA), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .length(length), .busy(busy), .done(done), .src_rd(src_rd), .src_addr(src_addr),
    .src_data(src_data), .vram_data(vram_data), .vram_address(vram_address),
    .vram_write_enable(vram_write_enable), .vram_select(vram_select),
    .in_vblank_select(in_vblank_select), .clr_irq_select(clr_irq_select),
    .status_in(status_in), .vblank_irq(vblank_irq), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (gpu_rst)                                     irq_q <= 1'b1;
    else if (irq_pulse)                              irq_q <= 1'b1;
    else if (clr_irq_select && vram_write_enable)    irq_q <= 1'b0;
  end
  assign vblank_irq = irq_q;
  assign status_in  = in_vblank_select ? {7'b0, vb} : 8'h00;

  always @(posedge clk) if (src_rd) src_data <= src_mem[src_addr];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [VA-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (vram_select || in_vblank_select || clr_irq_select)
        check("select_onehot", 64'($countones({vram_select, in_vblank_select, clr_irq_select})), 64'd1);
      if (vram_write_enable)
        check("we_qualified", 64'($countones({vram_select, clr_irq_select})), 64'd1);
      if (vram_write_enable && clr_irq_select) ack_cnt++;
      if (in_vblank_select) chk_cnt++;
      if (vram_write_enable && vram_select) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   vram_address, vram_data);
        end else begin
          check("vram_write", 64'({vram_address, vram_data}), 64'(exp_q.pop_front()));
        end
        run_len     = (last_wr_cyc == cyc - 1) ? run_len + 1 : 1;
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [SA-1:0] s, input logic [VA-1:0] d, input logic [LW-1:0] l);
    @(posedge clk);
    #1 start = 1'b1; src_base = s; dst_base = d; length = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic irq_edge(input logic writable);
    vb = writable;
    irq_pulse = 1'b1;
    @(posedge clk);
    #1 irq_pulse = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
    end
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wr_cnt >= target) break;
      @(negedge clk); #1;
    end
    check("write_count_reached", 64'(wr_cnt >= target), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int w0, d0, a0, c0;

  initial begin
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'h00;
    src_mem[16'h0100] = 8'hA1; src_mem[16'h0101] = 8'hB2;
    src_mem[16'h0102] = 8'hC3; src_mem[16'h0103] = 8'hD4;
    for (int i = 0; i < 10; i++) src_mem[16'h0300 + i] = 8'h30 + 8'(i);
    src_mem[16'hFFFE] = 8'h5A; src_mem[16'hFFFF] = 8'h6B;
    src_mem[16'h0000] = 8'h7C; src_mem[16'h0001] = 8'h8D;

    // Reset: outputs all zero while held.
    wait_cycles(3);
    check("reset_outputs", 64'({busy, done, src_rd, src_addr, vram_data, vram_address,
          vram_write_enable, vram_select, in_vblank_select, clr_irq_select, dbg_state}), 64'd0);
    #1 rst = 1'b1; gpu_rst = 1'b0;
    wait_cycles(2);

    // Zero length: done one cycle after start, never busy, no write.
    w0 = wr_cnt;
    start_xfer(16'h0100, 12'h100, 13'd0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    wait_cycles(1);
    check("len0_done_pulse_width", 64'(done), 64'd0);
    check("len0_busy_after", 64'(busy), 64'd0);
    check("len0_no_write", 64'(wr_cnt - w0), 64'd0);

    // Stale post-reset irq outside vblank: one ACK, one CHECK, back to waiting.
    a0 = ack_cnt; c0 = chk_cnt; w0 = wr_cnt; d0 = done_cnt;
    push_exp(12'h200, 8'hA1); push_exp(12'h201, 8'hB2);
    push_exp(12'h202, 8'hC3); push_exp(12'h203, 8'hD4);
    start_xfer(16'h0100, 12'h200, 13'd4);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_cycles(8);
    check("stale_irq_acks", 64'(ack_cnt - a0), 64'd1);
    check("stale_irq_checks", 64'(chk_cnt - c0), 64'd1);
    check("stale_irq_no_write", 64'(wr_cnt - w0), 64'd0);
    check("stale_irq_state", 64'(dbg_state), 64'd1);

    // Vblank entry: four back-to-back writes, done right after the last.
    irq_edge(1'b1);
    wait_done("len4_done", 100);
    check("len4_writes", 64'(wr_cnt - w0), 64'd4);
    check("len4_back_to_back", 64'(run_len), 64'd4);
    check("len4_done_latency", 64'(done_cyc - last_wr_cyc), 64'd1);
    wait_cycles(1);
    check("len4_idle_busy", 64'(busy), 64'd0);

    // Vblank ends after 6 of 10 writes; resumes at the next vblank.
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 10; i++) push_exp(12'h400 + 12'(i), 8'h30 + 8'(i));
    start_xfer(16'h0300, 12'h400, 13'd10);
    irq_edge(1'b1);
    wait_writes(w0 + 6, 100);
    irq_edge(1'b0);
    wait_cycles(6);
    check("split_first_frame", 64'(wr_cnt - w0), 64'd6);
    check("split_waiting", 64'(dbg_state), 64'd1);
    check("split_busy", 64'(busy), 64'd1);
    check("split_no_done", 64'(done_cnt - d0), 64'd0);
    start_xfer(16'h0100, 12'h000, 13'd3);
    irq_edge(1'b1);
    wait_done("split_done", 100);
    check("split_total", 64'(wr_cnt - w0), 64'd10);

    // Address wrap on both source and VRAM sides.
    w0 = wr_cnt;
    push_exp(12'hFFE, 8'h5A); push_exp(12'hFFF, 8'h6B);
    push_exp(12'h000, 8'h7C); push_exp(12'h001, 8'h8D);
    start_xfer(16'hFFFE, 12'hFFE, 13'd4);
    irq_edge(1'b1);
    wait_done("wrap_done", 100);
    check("wrap_writes", 64'(wr_cnt - w0), 64'd4);

    // Asynchronous reset mid-transfer: immediate quiet outputs, no done.
    w0 = wr_cnt; d0 = done_cnt;
    for (int i = 0; i < 8; i++) push_exp(12'h600 + 12'(i), 8'h30 + 8'(i));
    start_xfer(16'h0300, 12'h600, 13'd8);
    irq_edge(1'b1);
    wait_writes(w0 + 3, 100);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 64'({busy, done, src_rd, src_addr, vram_data, vram_address,
          vram_write_enable, vram_select, in_vblank_select, clr_irq_select, dbg_state}), 64'd0);
    check("abort_remaining", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    wait_cycles(3);
    #1 rst = 1'b1;
    wait_cycles(2);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Normal transfer after the abort.
    w0 = wr_cnt;
    push_exp(12'h700, 8'hA1); push_exp(12'h701, 8'hB2);
    start_xfer(16'h0100, 12'h700, 13'd2);
    irq_edge(1'b1);
    wait_done("post_reset_done", 100);
    check("post_reset_writes", 64'(wr_cnt - w0), 64'd2);

    wait_cycles(4);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Bus-master copy engine that uploads a byte block from a synchronous source RAM (program/work RAM) into GPU VRAM.
- Sits on the CPU side of the GPU's VRAM/vblank register interface and drives that interface in place of CPU stores.
- Uses the GPU vblank IRQ, IRQ-clear and in-vblank status protocol so every VRAM write lands only while VRAM is writable.
- Transfers resume across frames until the programmed length is done.

Parameters:
- VRAM_ADDR_WIDTH, 12, VRAM byte address width.
- SRC_ADDR_WIDTH, 16, source RAM address width.
- LEN_WIDTH, 13, transfer length counter width (max 2^LEN_WIDTH-1 bytes).

Ports:
- clk  in  1  system clock (GPU pixel clock domain)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches src_base/dst_base/length when IDLE
- src_base  in  SRC_ADDR_WIDTH  first source byte address
- dst_base  in  VRAM_ADDR_WIDTH  first VRAM byte address
- length  in  LEN_WIDTH  byte count
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- src_rd  out  1  source read strobe
- src_addr  out  SRC_ADDR_WIDTH  source read address
- src_data  in  8  source data, valid the cycle after src_rd
- vram_data  out  8  to GPU data_in
- vram_address  out  VRAM_ADDR_WIDTH  to GPU address
- vram_write_enable  out  1  to GPU write_enable
- vram_select  out  1  to GPU SELECT_vram
- in_vblank_select  out  1  to GPU SELECT_in_vblank
- clr_irq_select  out  1  to GPU SELECT_clr_vblank_irq
- status_in  in  8  GPU data_out; bit0 = writable when in_vblank_select is high
- vblank_irq  in  1  GPU vblank_irq (set on every writable edge and on GPU reset)

Behaviour:
- Reset (rst low, async): state IDLE, all outputs 0, counters cleared.
- States: IDLE, WAIT_IRQ, ACK, CHECK, XFER, FINISH.
- IDLE
  - start with length != 0: latch bases/length, busy=1, go to WAIT_IRQ.
  - start with length == 0: done pulses the next cycle, busy stays 0.
  - start while busy is ignored.
- WAIT_IRQ: hold until vblank_irq=1, then go to ACK.
- ACK: one cycle with vram_write_enable=1, clr_irq_select=1, vram_select=0; then go to CHECK.
- CHECK
  - one cycle with in_vblank_select=1; sample status_in[0] combinationally in the same cycle.
  - status_in[0]=1 (vblank entry): go to XFER.
  - status_in[0]=0 (vblank exit, or the post-reset IRQ outside vblank): go to WAIT_IRQ.
- XFER, 2-stage pipeline
  - Stage 1: src_rd=1, src_addr=src_base+rd_idx.
  - Stage 2, next cycle: vram_write_enable=1, vram_select=1, vram_address=dst_base+wr_idx, vram_data=src_data.
  - Throughput 1 byte/cycle after a 1-cycle fill; first write comes 1 cycle after XFER entry.
  - wr_idx advances only on a completed write; reads stop once rd_idx reaches length.
- XFER, vblank ends (vblank_irq=1 seen)
  - No new read and no write that cycle; the in-flight byte is discarded.
  - rd_idx is rewound to wr_idx; go to ACK. CHECK then reads 0 and the engine waits for the next vblank.
- XFER, completion: when wr_idx reaches length, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, all selects 0; go to IDLE.
- Address arithmetic: source and VRAM addresses wrap modulo 2^width; no carry into other fields.
- At most one of vram_select, in_vblank_select, clr_irq_select is high in any cycle.
- vram_write_enable is high only in ACK and in XFER write cycles.
- Simultaneous events
  - vblank_irq high in the same cycle as the final write: the write is suppressed and retried next vblank.
  - start in FINISH is ignored.
- Reset mid-transfer aborts with no done pulse. VRAM contents already written stay as written.

Test Plan:
- length=0 start -> done high exactly 1 cycle later; busy never asserted; no VRAM write.
- Post-reset vblank_irq=1 with status bit0=0 -> one ACK clear cycle, one CHECK cycle, return to WAIT_IRQ; zero VRAM writes.
- length=4, src 0x0100 holding {A1,B2,C3,D4}, dst_base=0x200, vblank IRQ with bit0=1 -> writes 0x200..0x203 = A1,B2,C3,D4 on 4 consecutive cycles; done 1 cycle after the last write.
- length=10; vblank ends (irq) after 6 writes -> 6 bytes written; at the next vblank, writes resume at dst+6 with src+6 data; 10 total, no duplicates or gaps.
- dst_base=0xFFE, length=4 with VRAM_ADDR_WIDTH=12 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- rst low mid-XFER -> all outputs 0 immediately (async), busy=0, no done; a new start afterwards behaves normally.
